// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between a PS/2 command source and ps2_host_tx.
// The master side issues bytes; the slave side reports handshake and completion.
interface ps2_host_tx_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready,
        input  busy,
        input  done,
        input  ack_ok,
        input  timeout
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready,
        output busy,
        output done,
        output ack_ok,
        output timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: clock inhibit, request-to-send,
// device-clocked shift of data/parity/stop, then ack check.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10_000,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    ps2_host_tx_if.slave cmd,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_data_oe_o
);

    localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StWaitIdle
    } state_e;

    state_e state_q, state_d;

    logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic             clk_filt_q, clk_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fall_q, fall_d;

    logic [InhW-1:0]  inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]   to_cnt_q, to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       frame_q, frame_d;
    logic             ack_q, ack_d;
    logic             shift_oe;

    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             timeout_q, timeout_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;

    // Idle lines float high, so synchronizers and filter reset to 1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
        end
    end

    // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_cnt_d = '0;
        clk_filt_d = clk_filt_q;
        if (clk_sync_q != clk_filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall_d = clk_filt_q & ~clk_filt_d;

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = '0;
        to_cnt_d  = '0;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        ack_ok_d  = ack_ok_q;
        timeout_d = timeout_q;
        shift_oe  = data_oe_q;

        unique case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (cmd.cmd_valid) begin
                    frame_d = {~^cmd.cmd_data, cmd.cmd_data};
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                to_cnt_d = to_cnt_q + 1'b1;
                state_d  = StShift;
            end
            StShift: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall_q) begin
                    // Shifting in ones makes the tenth strobe present the stop bit.
                    shift_oe  = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall_q) begin
                    ack_d   = ~data_sync_q;
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_filt_q && data_sync_q) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    ack_ok_d  = ack_q;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_q == StReq || state_q == StShift || state_q == StAck) &&
            to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = StIdle;
            done_d    = 1'b1;
            ack_ok_d  = 1'b0;
            timeout_d = 1'b1;
        end
    end

    // Line drives are registered from the next state so they track state_q glitch-free.
    always_comb begin
        clk_oe_d = (state_d == StInhibit) || (state_d == StReq);
        unique case (state_d)
            StReq:   data_oe_d = 1'b1;
            StShift: data_oe_d = shift_oe;
            default: data_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            timeout_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            timeout_q <= timeout_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    assign cmd.cmd_ready  = (state_q == StIdle);
    assign cmd.busy       = (state_q != StIdle);
    assign cmd.done       = done_q;
    assign cmd.ack_ok     = ack_ok_q;
    assign cmd.timeout    = timeout_q;
    assign ps2_clk_oe_o   = clk_oe_q;
    assign ps2_data_oe_o  = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model, table of frames, scoreboard
// of expected completions, plus timeout, reset-abort and back-to-back sequences.
module tb_ps2_host_tx;

    localparam int Half = 20;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_oe, data_oe;
    logic ps2_clk_line, ps2_data_line;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   req_cyc = 0;
    int   done_cyc = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(100),
        .TIMEOUT_CYCLES(5000),
        .FILTER_LEN    (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cmd          (bus),
        .ps2_clk_i    (ps2_clk_line),
        .ps2_data_i   (ps2_data_line),
        .ps2_clk_oe_o (clk_oe),
        .ps2_data_oe_o(data_oe)
    );

    assign ps2_clk_line  = dev_clk & ~clk_oe;
    assign ps2_data_line = dev_data & ~data_oe;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       dev_ack;
        logic       glitch;
        logic [9:0] exp_bits;  // {stop, parity, data}, bit 0 = first bit sent
        logic       exp_ack;
    } vec_t;

    typedef struct {
        logic [9:0] bits;
        logic       chk_bits;
        logic       ack_ok;
        logic       timeout;
    } sb_t;

    sb_t sb[$];

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic push, input sb_t e);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        if (push) sb.push_back(e);
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        int inh = 0;
        int req = 0;
        while (!clk_oe && n < 1000) begin
            tick();
            n++;
        end
        while (clk_oe && !data_oe && inh < 1000) begin
            inh++;
            tick();
        end
        while (clk_oe && data_oe && req < 10) begin
            if (req == 0) req_cyc = cyc;
            req++;
            tick();
        end
        check("inhibit_len", inh, 100);
        check("req_len", req, 1);
        check("start_bit", int'({clk_oe, data_oe}), 1);
    endtask

    // Device clocks n_falls falls; returns mid-low-phase if it stops early.
    task automatic device_frame(input int n_falls, input logic do_ack, input logic glitch,
                                output logic [9:0] bits);
        bits = '0;
        repeat (Half) tick();
        for (int k = 1; k <= n_falls; k++) begin
            dev_clk = 1'b0;
            repeat (Half) tick();
            if (k <= 10) bits[k-1] = ps2_data_line;
            if (k == n_falls && k < 11) return;
            dev_clk = 1'b1;
            if (k == 10 && do_ack) dev_data = 1'b0;
            if (k == 11) begin
                dev_data = 1'b1;
                return;
            end
            if (glitch && k == 3) begin
                repeat (8) tick();
                dev_clk = 1'b0;
                repeat (2) tick();
                dev_clk = 1'b1;
                repeat (Half - 10) tick();
            end else begin
                repeat (Half) tick();
            end
        end
    endtask

    task automatic wait_done(input logic [9:0] bits);
        int  n = 0;
        sb_t e;
        while (!bus.done && n < 6000) begin
            tick();
            n++;
        end
        check("done_seen", int'(bus.done), 1);
        if (bus.done) begin
            done_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: done with no expected entry");
            end else begin
                e = sb.pop_front();
                check("ack_ok", int'(bus.ack_ok), int'(e.ack_ok));
                check("timeout", int'(bus.timeout), int'(e.timeout));
                if (e.chk_bits) check("frame_bits", int'(bits), int'(e.bits));
            end
            check("oe_at_done", int'({clk_oe, data_oe}), 0);
            check("ready_at_done", int'(bus.cmd_ready), 1);
        end
    endtask

    task automatic after_done();
        tick();
        check("done_pulse_one", int'(bus.done), 0);
        check("busy_after", int'(bus.busy), 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [9:0] bits;
        sb_t        e;
        e.bits = v.exp_bits;
        e.chk_bits = 1'b1;
        e.ack_ok = v.exp_ack;
        e.timeout = 1'b0;
        send_cmd(v.data, 1'b1, e);
        wait_req();
        device_frame(11, v.dev_ack, v.glitch, bits);
        wait_done(bits);
        after_done();
    endtask

    initial begin
        vec_t       vecs[5];
        sb_t        e;
        logic [9:0] bits;
        int         dones;

        vecs[0] = '{8'hF4, 1'b1, 1'b0, 10'b10_1111_0100, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b0, 10'b11_0000_0000, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 10'b11_1111_1111, 1'b1};
        vecs[3] = '{8'hF4, 1'b0, 1'b0, 10'b10_1111_0100, 1'b0};
        vecs[4] = '{8'hF4, 1'b1, 1'b1, 10'b10_1111_0100, 1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        repeat (3) tick();
        check("rst_ready", int'(bus.cmd_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_ack_ok", int'(bus.ack_ok), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        check("rst_oe", int'({clk_oe, data_oe}), 0);
        rst_ni = 1'b1;
        repeat (10) tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Device never clocks: abort exactly TIMEOUT_CYCLES after REQ entry.
        e.bits = '0;
        e.chk_bits = 1'b0;
        e.ack_ok = 1'b0;
        e.timeout = 1'b1;
        send_cmd(8'hF4, 1'b1, e);
        wait_req();
        wait_done('0);
        check("timeout_latency", done_cyc - req_cyc, 5000);
        after_done();
        repeat (10) tick();

        // Reset after the fifth fall releases both lines at once, no done.
        send_cmd(8'h00, 1'b0, e);
        wait_req();
        device_frame(5, 1'b0, 1'b0, bits);
        check("pre_reset_data_oe", int'(data_oe), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("reset_oe", int'({clk_oe, data_oe}), 0);
        check("reset_ready", int'(bus.cmd_ready), 1);
        dev_clk = 1'b1;
        tick();
        rst_ni = 1'b1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.done) dones++;
        end
        check("no_done_after_reset", dones, 0);
        run_vec(vecs[0]);

        // cmd_valid held: second byte accepted on the cycle after the first done.
        e.chk_bits = 1'b1;
        e.timeout = 1'b0;
        e.ack_ok = 1'b1;
        e.bits = 10'b11_1010_1010;
        sb.push_back(e);
        e.bits = 10'b11_0101_0101;
        sb.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'hAA;
        tick();
        bus.cmd_data  = 8'h55;
        wait_req();
        check("ready_while_busy", int'(bus.cmd_ready), 0);
        device_frame(11, 1'b1, 1'b0, bits);
        wait_done(bits);
        tick();
        check("second_accept_oe", int'(clk_oe), 1);
        check("second_accept_busy", int'(bus.busy), 1);
        bus.cmd_valid = 1'b0;
        wait_req();
        device_frame(11, 1'b1, 1'b0, bits);
        wait_done(bits);
        after_done();

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 command transmitter; the outbound counterpart to the mouse receive path on PS2Clk/PS2Data.
- Sends one byte to the mouse per request using the standard sequence: clock inhibit, request-to-send, device-clocked shift, ack check. Typical commands are 0xF4 (enable reporting) and 0xFF (reset).
- Sits beside the PS/2 receiver. The top level maps the oe outputs to open-collector lines: PS2Clk = ps2_clk_oe ? 0 : Z, PS2Data = ps2_data_oe ? 0 : Z.
- busy tells the receiver to ignore line activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 10_000, clk cycles the clock line is held low before the request (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2_000_000, max clk cycles from REQ entry until ack is sampled (20 ms).
- FILTER_LEN, 4, consecutive identical synchronized samples required to accept a new ps2_clk level.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command byte is available.
- cmd_data  in  8  command byte.
- cmd_ready  out  1  block can accept a command; equals (state==IDLE).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transaction ends (completed or timed out).
- ack_ok  out  1  valid with done; 1 = device acknowledged.
- timeout  out  1  valid with done; 1 = aborted on timeout.
- ps2_clk_i  in  1  raw PS2Clk line level.
- ps2_data_i  in  1  raw PS2Data line level.
- ps2_clk_oe  out  1  1 = pull PS2Clk low.
- ps2_data_oe  out  1  1 = pull PS2Data low.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; both oe outputs 0; done, ack_ok, timeout, busy all 0; counters cleared.
  - cmd_ready reads 1, since it decodes IDLE.
  - Reset mid-transaction releases both lines immediately, with no partial frame completion.
- Input conditioning:
  - Both line inputs pass through 2-FF synchronizers.
  - The filtered clock changes level only after FILTER_LEN equal consecutive samples.
  - A falling edge is a filtered 1->0 transition; each edge produces one single-cycle fall strobe.
  - Data is sampled from the synchronized value at the fall strobe.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - cmd_data is latched; odd parity is computed as ~^cmd_data.
  - No command is accepted again until the FSM returns to IDLE.
- States:
  - IDLE: both oe = 0.
  - INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles starting the cycle after accept; ps2_data_oe = 0.
  - REQ: one cycle with ps2_clk_oe = 1 and ps2_data_oe = 1, then go to SHIFT. The timeout counter starts here.
  - SHIFT:
    - ps2_clk_oe = 0 and ps2_data_oe = 1 (start bit) until the first fall strobe.
    - Fall strobes 1..8 each present data bit 0..7 (LSB first), as ps2_data_oe = ~bit.
    - Fall strobe 9 presents parity.
    - Fall strobe 10 presents the stop bit: ps2_data_oe = 0.
    - 4-bit counter; go to ACK after strobe 10.
  - ACK: on fall strobe 11, latch ack = ~data_sync, then go to WAIT_IDLE.
  - WAIT_IDLE: wait until the filtered clock and synchronized data are both 1, then go to IDLE. In that transition cycle: done = 1, ack_ok = latched ack, timeout = 0.
- Timeout:
  - Applies while in REQ, SHIFT, or ACK.
  - When the counter reaches TIMEOUT_CYCLES: both oe = 0 in the next cycle, go to IDLE, pulse done = 1 with timeout = 1 and ack_ok = 0.
  - WAIT_IDLE has no timeout. If the lines never return high, busy stays high (documented limitation).
- Outputs:
  - ack_ok and timeout are registered and hold their value until the next done pulse.
  - All outputs are registered except cmd_ready and busy.
- Boundary cases:
  - Fall strobes seen in IDLE or INHIBIT are ignored.
  - A device pulling data low during SHIFT does not alter the sequence.
  - An extra fall strobe in WAIT_IDLE is ignored.
  - A new cmd_valid during done is accepted on the following cycle, because IDLE is reached together with done.

Test Plan:
(Bench parameters: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=5000, FILTER_LEN=4. Device model clocks at 20-cycle half periods.)
- Accept 0xF4:
  - ps2_clk_oe must be high for exactly 100 cycles, then one REQ cycle with both oe high.
  - Bits observed on device falls 1..10: 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - Device acks low on fall 11 -> done pulse with ack_ok=1, timeout=0; busy then low.
- Send 0x00, then 0xFF: parity bit is 1 for both; each frame is 11 device clocks; each byte ends with done, ack_ok=1.
- Device leaves data high on fall 11 (nack) -> done with ack_ok=0, timeout=0; both oe=0.
- Device never clocks after REQ -> exactly 5000 cycles after REQ entry: done=1, timeout=1, ack_ok=0, both oe=0, cmd_ready=1.
- Glitch and reset:
  - 2-cycle low glitch on ps2_clk_i during SHIFT -> no bit advance; frame still matches 0xF4.
  - Assert reset after fall 5 -> both oe=0 immediately; no done pulse.
  - Next command sends a clean full frame.
- cmd_valid held high with 0xAA then 0x55 -> second byte accepted only in the cycle after the first done. Parity bits: 1 for 0xAA, 1 for 0x55.
